// File: rtl/alu_stim_driver.sv
//------------------------------------------------------------------------------
// Module   : alu_stim_driver
// Purpose  : Seed-reproducible ALU transaction source on a valid/ready port.
//            Optional corner phase enabled by defining ALU_STIM_CORNER_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_stim_driver #(
    parameter int          WIDTH    = 32,
    parameter int          OPCODE_W = 4,
    parameter int          NUM_OPS  = 11,
    parameter int          NUM_TXN  = 256,
    parameter logic [31:0] SEED     = 32'hACE1_2468
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_operand_a,
    output logic [WIDTH-1:0]    out_operand_b,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic                out_signed,
    output logic [15:0]         out_id,
    output logic [15:0]         txn_count
);

    localparam logic [31:0]         C_LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0]         C_SEED_B    = SEED ^ 32'h5A5A_5A5A;
    localparam logic [15:0]         C_LAST_ID   = 16'(NUM_TXN - 1);
    localparam logic [OPCODE_W-1:0] C_LAST_OP   = OPCODE_W'(NUM_OPS - 1);
    localparam logic [OPCODE_W-1:0] C_OP_ONE    = OPCODE_W'(1);
    localparam logic [WIDTH-1:0]    C_ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0]    C_MSB       = C_ONE << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ C_LFSR_MASK) : (v >> 1);
    endfunction

    state_t              state_q, state_d;
    logic [31:0]         lfsr_a_q, lfsr_a_d;
    logic [31:0]         lfsr_b_q, lfsr_b_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic                sgn_q, sgn_d;
    logic [15:0]         cnt_q, cnt_d;
`ifdef ALU_STIM_CORNER_EN
    logic                corner_q, corner_d;
    logic [1:0]          pair_q, pair_d;
    logic [OPCODE_W-1:0] corner_op_q, corner_op_d;
`endif

    logic                w_hs;
    logic [WIDTH-1:0]    w_a;
    logic [WIDTH-1:0]    w_b;
    logic [OPCODE_W-1:0] w_op;
    logic                w_sgn;

    assign w_hs = (state_q == S_RUN) && out_ready;

    always_comb begin
        state_d  = state_q;
        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        opcode_d = opcode_q;
        sgn_d    = sgn_q;
        cnt_d    = cnt_q;
`ifdef ALU_STIM_CORNER_EN
        corner_d    = corner_q;
        pair_d      = pair_q;
        corner_op_d = corner_op_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = 16'd0;
                    state_d = (NUM_TXN > 0) ? S_RUN : S_DONE;
`ifdef ALU_STIM_CORNER_EN
                    corner_d    = 1'b1;
                    pair_d      = 2'd0;
                    corner_op_d = '0;
`endif
                end
            end
            S_RUN: begin
                if (w_hs) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == C_LAST_ID) begin
                        state_d = S_DONE;
                    end
`ifdef ALU_STIM_CORNER_EN
                    if (corner_q) begin
                        // Corner sweep uses its own opcode counter; random phase restarts clean.
                        if (corner_op_q == C_LAST_OP) begin
                            corner_op_d = '0;
                            pair_d      = pair_q + 2'd1;
                            if (pair_q == 2'd3) begin
                                corner_d = 1'b0;
                                opcode_d = '0;
                                sgn_d    = 1'b0;
                            end
                        end else begin
                            corner_op_d = corner_op_q + C_OP_ONE;
                        end
                    end else
`endif
                    begin
                        lfsr_a_d = lfsr_step(lfsr_a_q);
                        lfsr_b_d = lfsr_step(lfsr_b_q);
                        if (opcode_q == C_LAST_OP) begin
                            opcode_d = '0;
                            sgn_d    = ~sgn_q;
                        end else begin
                            opcode_d = opcode_q + C_OP_ONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_a_q <= SEED;
            lfsr_b_q <= C_SEED_B;
            opcode_q <= '0;
            sgn_q    <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
            opcode_q <= opcode_d;
            sgn_q    <= sgn_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef ALU_STIM_CORNER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            corner_q    <= 1'b0;
            pair_q      <= 2'd0;
            corner_op_q <= '0;
        end else begin
            corner_q    <= corner_d;
            pair_q      <= pair_d;
            corner_op_q <= corner_op_d;
        end
    end

    always_comb begin
        w_a   = lfsr_a_q[WIDTH-1:0];
        w_b   = lfsr_b_q[WIDTH-1:0];
        w_op  = opcode_q;
        w_sgn = sgn_q;
        if (corner_q) begin
            w_op  = corner_op_q;
            w_sgn = 1'b1;
            case (pair_q)
                2'd0:    begin w_a = '0;     w_b = '0;     end
                2'd1:    begin w_a = '1;     w_b = C_ONE;  end
                2'd2:    begin w_a = C_MSB;  w_b = C_MSB;  end
                default: begin w_a = ~C_MSB; w_b = C_ONE;  end
            endcase
        end
    end
`else
    always_comb begin
        w_a   = lfsr_a_q[WIDTH-1:0];
        w_b   = lfsr_b_q[WIDTH-1:0];
        w_op  = opcode_q;
        w_sgn = sgn_q;
    end
`endif

    // Payload is forced to zero whenever nothing is being offered.
    assign out_valid     = (state_q == S_RUN);
    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign out_operand_a = out_valid ? w_a   : '0;
    assign out_operand_b = out_valid ? w_b   : '0;
    assign out_opcode    = out_valid ? w_op  : '0;
    assign out_signed    = out_valid ? w_sgn : 1'b0;
    assign out_id        = out_valid ? cnt_q : 16'd0;
    assign txn_count     = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_stim_driver.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_stim_driver
// Purpose  : Scoreboard bench for alu_stim_driver (reference model + queue).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_stim_driver;

    localparam int          WIDTH    = 32;
    localparam int          OPCODE_W = 4;
    localparam int          NUM_OPS  = 11;
    localparam int          NUM_TXN  = 23;
    localparam logic [31:0] SEED     = 32'hACE1_2468;
    localparam logic [31:0] MASK     = 32'h8020_0003;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        sgn;
        logic [15:0] id;
    } txn_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                busy;
    logic                done;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_operand_a;
    logic [WIDTH-1:0]    out_operand_b;
    logic [OPCODE_W-1:0] out_opcode;
    logic                out_signed;
    logic [15:0]         out_id;
    logic [15:0]         txn_count;

    int total = 0;
    int bad   = 0;

    txn_t        exp_q[$];
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_op;
    logic        m_sgn;

    alu_stim_driver #(
        .WIDTH    (WIDTH),
        .OPCODE_W (OPCODE_W),
        .NUM_OPS  (NUM_OPS),
        .NUM_TXN  (NUM_TXN),
        .SEED     (SEED)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_operand_a (out_operand_a),
        .out_operand_b (out_operand_b),
        .out_opcode    (out_opcode),
        .out_signed    (out_signed),
        .out_id        (out_id),
        .txn_count     (txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] v);
        logic [31:0] r;
        r = {1'b0, v[31:1]};
        if (v[0]) r = r ^ MASK;
        return r;
    endfunction

    task automatic model_reset();
        m_a   = SEED;
        m_b   = SEED ^ 32'h5A5A_5A5A;
        m_op  = 4'd0;
        m_sgn = 1'b0;
    endtask

    // Expected transactions for one run; model state advances as the DUT's should.
    task automatic push_run();
        txn_t e;
        for (int i = 0; i < NUM_TXN; i++) begin
            e.id = 16'(i);
`ifdef ALU_STIM_CORNER_EN
            if (i < 4 * NUM_OPS) begin
                e.op  = 4'(i % NUM_OPS);
                e.sgn = 1'b1;
                case (i / NUM_OPS)
                    0:       begin e.a = 32'h0000_0000; e.b = 32'h0000_0000; end
                    1:       begin e.a = 32'hFFFF_FFFF; e.b = 32'h0000_0001; end
                    2:       begin e.a = 32'h8000_0000; e.b = 32'h8000_0000; end
                    default: begin e.a = 32'h7FFF_FFFF; e.b = 32'h0000_0001; end
                endcase
                if (i == 4 * NUM_OPS - 1) begin
                    m_op  = 4'd0;
                    m_sgn = 1'b0;
                end
                exp_q.push_back(e);
                continue;
            end
`endif
            e.a   = m_a;
            e.b   = m_b;
            e.op  = m_op;
            e.sgn = m_sgn;
            exp_q.push_back(e);
            m_a = step(m_a);
            m_b = step(m_b);
            if (m_op == 4'(NUM_OPS - 1)) begin
                m_op  = 4'd0;
                m_sgn = ~m_sgn;
            end else begin
                m_op = m_op + 4'd1;
            end
        end
    endtask

    task automatic do_run(input bit stall, input int abort_id, input bit hold_start, input bit first_run);
        int   stall_cnt = 0;
        int   cycles    = 0;
        bit   aborted   = 0;
        txn_t e;
        txn_t o;
        start = 1'b1;
        push_run();
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        chk("busy_after_start", {127'd0, busy}, 128'd1);
        while (exp_q.size() > 0 && cycles < 400) begin
            e = exp_q[0];
            o.a = out_operand_a; o.b = out_operand_b; o.op = out_opcode;
            o.sgn = out_signed;  o.id = out_id;
            chk("valid_held", {127'd0, out_valid}, 128'd1);
            chk("payload", {43'd0, o}, {43'd0, e});
`ifndef ALU_STIM_CORNER_EN
            if (first_run && e.id == 16'd0) begin
                chk("first_a", {96'd0, o.a}, {96'd0, 32'hACE1_2468});
                chk("first_b", {96'd0, o.b}, {96'd0, 32'hF6BB_7E32});
            end
            if (first_run && e.id == 16'd1)
                chk("second_a", {96'd0, o.a}, {96'd0, 32'h5670_9234});
`endif
            if (abort_id >= 0 && int'(e.id) == abort_id) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("abort_valid", {127'd0, out_valid}, 128'd0);
                chk("abort_busy", {127'd0, busy}, 128'd0);
                chk("abort_done", {127'd0, done}, 128'd0);
                exp_q.delete();
                model_reset();
                aborted = 1;
                @(posedge clk); #1;
                chk("abort_no_done", {127'd0, done}, 128'd0);
                break;
            end
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else begin
                out_ready = 1'b1;
            end
            if (out_ready) begin
                void'(exp_q.pop_front());
                if (stall && e.id == 16'd1) stall_cnt = 5;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        if (cycles >= 400) begin
            bad++;
            total++;
            $display("FAIL run_timeout observed=%0d expected<400", cycles);
            exp_q.delete();
        end
        if (!aborted) begin
            chk("end_valid", {127'd0, out_valid}, 128'd0);
            chk("end_busy", {127'd0, busy}, 128'd0);
            chk("end_done", {127'd0, done}, 128'd1);
            chk("end_count", {112'd0, txn_count}, {112'd0, 16'(NUM_TXN)});
            @(posedge clk); #1;
            chk("done_pulse_end", {127'd0, done}, 128'd0);
            chk("count_hold", {112'd0, txn_count}, {112'd0, 16'(NUM_TXN)});
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_count", {112'd0, txn_count}, 128'd0);
        chk("rst_a", {96'd0, out_operand_a}, 128'd0);
        chk("rst_id", {112'd0, out_id}, 128'd0);
        // out_ready high while idle must not start anything
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_valid", {127'd0, out_valid}, 128'd0);

        do_run(1'b1, -1, 1'b0, 1'b1);
        do_run(1'b0, 7, 1'b0, 1'b0);
        do_run(1'b0, -1, 1'b1, 1'b1);
        do_run(1'b0, -1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
